// File: rtl/timer_pkg.sv
// Shared timekeeping definitions used by the countdown timer and the elapsed-time counter.
package timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_PAUSED  = 2'd2,
        ST_EXPIRED = 2'd3
    } timer_state_e;

    localparam int unsigned TIME_MAX_VAL = 59;

    typedef logic [5:0] time_field_t;

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk into a one-cycle tick every TICK_DIV enabled cycles; clr restarts the count.
module tick_prescaler #(
    parameter int unsigned TICK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        tick  = en && (cnt_q == LAST);
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tick ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/countdown_timer.sv
// MM:SS countdown timer with load/start/pause commands and a one-cycle done pulse at 00:00.
//   state      | meaning
//   ST_IDLE    | value loaded, not counting
//   ST_RUN     | decrementing once per tick
//   ST_PAUSED  | counts and prescaler frozen
//   ST_EXPIRED | reached 00:00, waits for load
module countdown_timer
    import timer_pkg::*;
#(
    parameter int unsigned TICK_DIV = 4,
    parameter int unsigned MAX_VAL  = TIME_MAX_VAL
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [5:0] load_min,
    input  logic [5:0] load_sec,
    input  logic       start,
    input  logic       pause,
    output logic [5:0] minute,
    output logic [5:0] second,
    output logic       running,
    output logic       done,
    output logic       load_err
);

    localparam time_field_t MAX_F = time_field_t'(MAX_VAL);

    timer_state_e state_q, state_d;
    time_field_t  min_q, min_d, sec_q, sec_d;
    logic         running_q, running_d;
    logic         done_q, done_d;
    logic         load_err_q, load_err_d;
    logic         load_ok, pause_cmd, presc_en, presc_clr, tick;

    assign load_ok   = load && (load_min <= MAX_F) && (load_sec <= MAX_F);
    assign pause_cmd = pause && !load;
    // A pause arriving on the tick cycle must swallow that tick.
    assign presc_en  = (state_q == ST_RUN) && !pause_cmd && !load_ok;

    tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (presc_en),
        .clr   (presc_clr),
        .tick  (tick)
    );

    always_comb begin
        state_d    = state_q;
        min_d      = min_q;
        sec_d      = sec_q;
        done_d     = 1'b0;
        load_err_d = 1'b0;
        presc_clr  = 1'b0;

        if (load) begin
            if (load_ok) begin
                min_d     = load_min;
                sec_d     = load_sec;
                state_d   = ST_IDLE;
                presc_clr = 1'b1;
            end else begin
                load_err_d = 1'b1;
            end
        end else if (pause) begin
            if (state_q == ST_RUN) begin
                state_d = ST_PAUSED;
            end
        end else if (start) begin
            if (state_q == ST_IDLE && (min_q != '0 || sec_q != '0)) begin
                state_d   = ST_RUN;
                presc_clr = 1'b1;
            end else if (state_q == ST_PAUSED) begin
                state_d = ST_RUN;
            end
        end

        if (tick) begin
            if (sec_q != '0) begin
                sec_d = sec_q - 1'b1;
            end else if (min_q != '0) begin
                min_d = min_q - 1'b1;
                sec_d = MAX_F;
            end
            if (min_q == '0 && sec_q == 6'd1) begin
                state_d = ST_EXPIRED;
                done_d  = 1'b1;
            end
        end

        running_d = (state_d == ST_RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            min_q      <= '0;
            sec_q      <= '0;
            running_q  <= 1'b0;
            done_q     <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            min_q      <= min_d;
            sec_q      <= sec_d;
            running_q  <= running_d;
            done_q     <= done_d;
            load_err_q <= load_err_d;
        end
    end

    assign minute   = min_q;
    assign second   = sec_q;
    assign running  = running_q;
    assign done     = done_q;
    assign load_err = load_err_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer at TICK_DIV=4 with hand-computed expected values.
module tb_countdown_timer;

    logic       clk;
    logic       rst_n;
    logic       load;
    logic [5:0] load_min;
    logic [5:0] load_sec;
    logic       start;
    logic       pause;
    logic [5:0] minute;
    logic [5:0] second;
    logic       running;
    logic       done;
    logic       load_err;

    int n_checks;
    int n_pass;
    int done_cnt;

    countdown_timer #(.TICK_DIV(4), .MAX_VAL(59)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .load_min (load_min),
        .load_sec (load_sec),
        .start    (start),
        .pause    (pause),
        .minute   (minute),
        .second   (second),
        .running  (running),
        .done     (done),
        .load_err (load_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (done) done_cnt++;
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive a command for exactly one posedge; returns at the negedge after it.
    task automatic cmd(input logic ld, input int mm, input int ss, input logic st, input logic pa);
        load     = ld;
        load_min = 6'(mm);
        load_sec = 6'(ss);
        start    = st;
        pause    = pa;
        @(negedge clk);
        load  = 1'b0;
        start = 1'b0;
        pause = 1'b0;
    endtask

    initial begin
        int base;
        n_checks = 0;
        n_pass   = 0;
        done_cnt = 0;
        rst_n    = 1'b0;
        load     = 1'b0;
        load_min = '0;
        load_sec = '0;
        start    = 1'b0;
        pause    = 1'b0;
        cyc(2);
        chk("rst_minute", minute, 0);
        chk("rst_second", second, 0);
        chk("rst_running", running, 0);
        chk("rst_done", done, 0);
        chk("rst_load_err", load_err, 0);
        rst_n = 1'b1;
        cyc(1);

        // 1: 01:05 runs down to 00:00 in 260 cycles
        cmd(1'b1, 1, 5, 1'b0, 1'b0);
        chk("t1_load_min", minute, 1);
        chk("t1_load_sec", second, 5);
        chk("t1_idle_running", running, 0);
        cmd(1'b0, 0, 0, 1'b1, 1'b0);
        chk("t1_running", running, 1);
        cyc(3);
        chk("t1_before_tick", second, 5);
        cyc(1);
        chk("t1_first_tick_min", minute, 1);
        chk("t1_first_tick_sec", second, 4);
        base = done_cnt;
        cyc(255);
        chk("t1_pre_zero_sec", second, 1);
        chk("t1_pre_zero_done", done, 0);
        cyc(1);
        chk("t1_zero_min", minute, 0);
        chk("t1_zero_sec", second, 0);
        chk("t1_done", done, 1);
        chk("t1_expired_running", running, 0);
        cyc(1);
        chk("t1_done_cleared", done, 0);
        cmd(1'b0, 0, 0, 1'b1, 1'b0);
        cyc(5);
        chk("t1_expired_start_ignored", running, 0);
        chk("t1_expired_sec", second, 0);
        chk("t1_done_pulses", done_cnt - base, 1);

        // 2: minute borrow 01:00 -> 00:59
        cmd(1'b1, 1, 0, 1'b0, 1'b0);
        cmd(1'b0, 0, 0, 1'b1, 1'b0);
        cyc(4);
        chk("t2_borrow_min", minute, 0);
        chk("t2_borrow_sec", second, 59);

        // 3: pause mid-second and resume
        cmd(1'b1, 0, 10, 1'b0, 1'b0);
        cmd(1'b0, 0, 0, 1'b1, 1'b0);
        cyc(4);
        chk("t3_first_tick", second, 9);
        cyc(2);
        cmd(1'b0, 0, 0, 1'b0, 1'b1);
        chk("t3_paused_running", running, 0);
        cyc(20);
        chk("t3_frozen_sec", second, 9);
        cmd(1'b0, 0, 0, 1'b1, 1'b0);
        chk("t3_resumed_running", running, 1);
        cyc(1);
        chk("t3_resume_hold", second, 9);
        cyc(1);
        chk("t3_resume_tick", second, 8);

        // 5: load beats start in RUN; pause beats start in PAUSED
        cmd(1'b1, 0, 3, 1'b1, 1'b0);
        chk("t5_load_over_start_sec", second, 3);
        chk("t5_load_over_start_running", running, 0);
        cmd(1'b0, 0, 0, 1'b1, 1'b0);
        cmd(1'b0, 0, 0, 1'b0, 1'b1);
        cmd(1'b0, 0, 0, 1'b1, 1'b1);
        chk("t5_start_pause_running", running, 0);
        cyc(6);
        chk("t5_start_pause_sec", second, 3);

        // 4: illegal loads rejected; 00:00 start ignored
        cmd(1'b1, 0, 60, 1'b0, 1'b0);
        chk("t4_err_sec", load_err, 1);
        chk("t4_err_keep_sec", second, 3);
        cyc(1);
        chk("t4_err_pulse_len", load_err, 0);
        cmd(1'b1, 60, 0, 1'b0, 1'b0);
        chk("t4_err_min", load_err, 1);
        chk("t4_err_keep_min", minute, 0);
        cmd(1'b1, 59, 59, 1'b0, 1'b0);
        chk("t4_max_legal_err", load_err, 0);
        chk("t4_max_legal_min", minute, 59);
        cmd(1'b1, 0, 0, 1'b0, 1'b0);
        base = done_cnt;
        cmd(1'b0, 0, 0, 1'b1, 1'b0);
        chk("t4_zero_start_running", running, 0);
        cyc(8);
        chk("t4_zero_no_done", done_cnt - base, 0);

        // 6: asynchronous reset mid-run
        cmd(1'b1, 0, 2, 1'b0, 1'b0);
        cmd(1'b0, 0, 0, 1'b1, 1'b0);
        cyc(2);
        base = done_cnt;
        #2 rst_n = 1'b0;
        #1;
        chk("t6_async_sec", second, 0);
        chk("t6_async_running", running, 0);
        chk("t6_async_done", done, 0);
        cyc(6);
        rst_n = 1'b1;
        cmd(1'b0, 0, 0, 1'b1, 1'b0);
        chk("t6_post_rst_start", running, 0);
        cyc(6);
        chk("t6_post_rst_sec", second, 0);
        chk("t6_no_done", done_cnt - base, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
